// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the vector dot-product processing element.
//   PE_DATA_WIDTH  default operand / product / accumulator width
//   PE_L_RAM_SIZE  default log2 depth of the local operand RAM
//   SAT_MAX/SAT_MIN  signed 32-bit clamp bounds used when saturation is built in
//   stage_ctl_t    per-stage valid/last bundle, also used by matrix_pe_con
package pe_pkg;

  localparam int PE_DATA_WIDTH = 32;
  localparam int PE_L_RAM_SIZE = 6;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic v;
    logic last;
  } stage_ctl_t;

endpackage

// File: rtl/pe_local_ram.sv
// pe_local_ram: single-port 2^ADDR_W x DATA_W operand store.
//   clk    clock
//   we     write din into mem[addr]
//   addr   shared read/write address
//   din    write data
//   rdata  registered read of mem[addr]; returns the word present before
//          a same-edge write (read-before-write)
// Contents are not reset so the array maps onto block or distributed RAM.
module pe_local_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vector_dot_pe.sv
// vector_dot_pe: holds one operand vector in local RAM and accumulates the
// element-wise product with a streamed vector, emitting one dot product per
// vector (3-stage pipeline: read/register, multiply, accumulate).
//   aclk, areset  clock, asynchronous active-high reset
//   we, addr, din local RAM load port (addr also indexes the compute read)
//   valid, ain    streamed element and its qualifier
//   last          marks the final element of a vector (only with valid)
//   clear         synchronous flush of pipeline and accumulator
//   dout, dvalid  result and its one-cycle strobe; dout holds between results
//   busy          some pipeline stage holds an element
// Build option: define SATURATE_EN to clamp the product and the running sum
// to the signed DATA_WIDTH range; otherwise both wrap modulo 2^DATA_WIDTH.
module vector_dot_pe
  import pe_pkg::*;
#(
  parameter int L_RAM_SIZE = PE_L_RAM_SIZE,
  parameter int DATA_WIDTH = PE_DATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  we,
  input  logic [L_RAM_SIZE-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] ain,
  input  logic                  last,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid,
  output logic                  busy
);

  // Stage 1: registered operand plus RAM word read at the same edge.
  stage_ctl_t                   s1_ctl;
  logic signed [DATA_WIDTH-1:0] s1_a;
  logic signed [DATA_WIDTH-1:0] s1_b;

  // Stage 2: reduced product.
  stage_ctl_t                   s2_ctl;
  logic signed [DATA_WIDTH-1:0] s2_prod;

  // Stage 3: accumulator; s3_v marks that the accumulate stage just
  // consumed an element, keeping busy high until the result is out.
  logic signed [DATA_WIDTH-1:0] acc;
  logic                         s3_v;

  logic signed [DATA_WIDTH-1:0] prod_next;
  logic signed [DATA_WIDTH-1:0] acc_sum;

  pe_local_ram #(
    .ADDR_W (L_RAM_SIZE),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .clk   (aclk),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .rdata (s1_b)
  );

`ifdef SATURATE_EN
  localparam logic signed [2*DATA_WIDTH-1:0] PROD_MAX =
    {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [2*DATA_WIDTH-1:0] PROD_MIN =
    {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] full_prod;
  logic signed [DATA_WIDTH:0]     wide_sum;

  assign full_prod = s1_a * s1_b;

  always_comb begin
    prod_next = full_prod[DATA_WIDTH-1:0];
    if (full_prod > PROD_MAX) begin
      prod_next = ACC_MAX;
    end else if (full_prod < PROD_MIN) begin
      prod_next = ACC_MIN;
    end
  end

  // One guard bit: overflow when the top two bits disagree, and the
  // guard bit gives the true sign of the unbounded sum.
  assign wide_sum = {acc[DATA_WIDTH-1], acc} + {s2_prod[DATA_WIDTH-1], s2_prod};

  always_comb begin
    acc_sum = wide_sum[DATA_WIDTH-1:0];
    if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
      acc_sum = wide_sum[DATA_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  // Low DATA_WIDTH bits of the signed product are the wrapped result.
  assign prod_next = s1_a * s1_b;
  assign acc_sum   = acc + s2_prod;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_ctl  <= '0;
      s1_a    <= '0;
      s2_ctl  <= '0;
      s2_prod <= '0;
      s3_v    <= 1'b0;
      acc     <= '0;
      dout    <= '0;
      dvalid  <= 1'b0;
    end else if (clear) begin
      // Flush control and partial sum; data registers and dout keep their
      // values since nothing downstream looks at them without a valid.
      s1_ctl <= '0;
      s2_ctl <= '0;
      s3_v   <= 1'b0;
      acc    <= '0;
      dvalid <= 1'b0;
    end else begin
      s1_ctl.v    <= valid;
      s1_ctl.last <= valid & last;
      s1_a        <= ain;

      s2_ctl  <= s1_ctl;
      s2_prod <= prod_next;

      s3_v   <= s2_ctl.v;
      dvalid <= 1'b0;
      if (s2_ctl.v) begin
        if (s2_ctl.last) begin
          dout   <= acc_sum;
          dvalid <= 1'b1;
          acc    <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  assign busy = s1_ctl.v | s2_ctl.v | s3_v;

endmodule

// File: tb/tb_vector_dot_pe.sv
// tb_vector_dot_pe: scoreboard bench for vector_dot_pe. The driver updates a
// behavioural model (operand array + running sum) and queues each expected
// result with the cycle it is due; a free-running monitor checks every
// dvalid against the queue and checks busy every cycle.
module tb_vector_dot_pe;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        we = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] din = '0;
  logic        valid = 1'b0;
  logic [31:0] ain = '0;
  logic        last = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] dout;
  logic        dvalid;
  logic        busy;

  vector_dot_pe dut (
    .aclk   (aclk),
    .areset (areset),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .valid  (valid),
    .ain    (ain),
    .last   (last),
    .clear  (clear),
    .dout   (dout),
    .dvalid (dvalid),
    .busy   (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [64];
  logic [31:0] acc_m = '0;
  logic [31:0] last_result = '0;
  int          cyc = 0;
  int          last_acc = -100;
  int          last_kill = 0;
  int          checks = 0;
  int          errors = 0;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Arithmetic of the spec, written with wide integers.
  function automatic logic [31:0] mul_red(input logic [31:0] a, input logic [31:0] b);
`ifdef SATURATE_EN
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
    return p[31:0];
`else
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
`endif
  endfunction

  function automatic logic [31:0] add_red(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  function automatic void purge_from(input int edge_no);
    exp_t keep[$];
    foreach (exp_q[i]) begin
      if (exp_q[i].due < edge_no) keep.push_back(exp_q[i]);
    end
    exp_q = keep;
  endfunction

  // Drive one cycle of inputs and advance the model for the next edge.
  task automatic step(input logic w, input logic [5:0] a, input logic [31:0] d,
                      input logic v, input logic [31:0] x, input logic l,
                      input logic c);
    int          e;
    logic [31:0] p;
    logic [31:0] s;
    @(negedge aclk);
    we = w; addr = a; din = d; valid = v; ain = x; last = l; clear = c;
    e = cyc + 1;
    if (c) begin
      purge_from(e);
      acc_m = '0;
      last_kill = e;
    end else if (v) begin
      p = mul_red(x, mem_m[a]);
      s = add_red(acc_m, p);
      last_acc = e;
      if (l) begin
        exp_q.push_back('{val: s, due: e + 2});
        acc_m = '0;
      end else begin
        acc_m = s;
      end
    end
    if (w) mem_m[a] = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: result and busy checks one time unit after every edge.
  initial forever begin
    logic exp_busy;
    exp_t ex;
    @(posedge aclk);
    #1;
    if (!areset) begin
      checks++;
      exp_busy = (last_acc >= cyc - 2) && (last_acc > last_kill);
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      if (dvalid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dvalid cyc=%0d dout=%h", cyc, dout);
        end else begin
          ex = exp_q.pop_front();
          last_result = ex.val;
          if (dout !== ex.val || cyc != ex.due) begin
            errors++;
            $display("FAIL result cyc=%0d got=%h exp=%h due=%0d", cyc, dout, ex.val, ex.due);
          end else begin
            $display("result cyc=%0d dout=%h ok", cyc, dout);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checks++;
        errors++;
        ex = exp_q.pop_front();
        $display("FAIL missing_result cyc=%0d exp=%h due=%0d", cyc, ex.val, ex.due);
      end
    end
  end

  initial begin
    int len;
    foreach (mem_m[i]) mem_m[i] = '0;

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk);
      #1;
      checks++;
      if (dout !== 32'd0 || dvalid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc=%0d dout=%h dvalid=%b busy=%b exp 0/0/0", cyc, dout, dvalid, busy);
      end
    end
    @(negedge aclk);
    areset = 1'b0;
    last_kill = cyc;

    // Basic 4-element dot product.
    for (int i = 0; i < 4; i++) step(1'b1, 6'(i), 32'(i + 1), 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 6'(i), 32'd0, 1'b1, 32'(i + 5), (i == 3), 1'b0);
    idle(5);

    // Back-to-back 2-element vectors.
    step(1'b1, 6'd10, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 6'd11, -32'sd2, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 6'd10, 32'd0, 1'b1, 32'd4, 1'b0, 1'b0);
    step(1'b0, 6'd11, 32'd0, 1'b1, 32'd5, 1'b1, 1'b0);
    step(1'b0, 6'd10, 32'd0, 1'b1, -32'sd1, 1'b0, 1'b0);
    step(1'b0, 6'd11, 32'd0, 1'b1, -32'sd1, 1'b1, 1'b0);
    idle(5);

    // Write and read of the same word on one edge.
    step(1'b1, 6'd7, 32'd10, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 6'd7, 32'd20, 1'b1, 32'd1, 1'b1, 1'b0);
    idle(5);

    // Clear mid-vector: no result, dout retained, next vector clean.
    step(1'b0, 6'd0, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0);
    step(1'b0, 6'd1, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0);
    step(1'b0, 6'd2, 32'd0, 1'b1, 32'd9, 1'b0, 1'b1);
    @(posedge aclk);
    #1;
    checks++;
    if (dout !== last_result || dvalid !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold dout=%h dvalid=%b exp dout=%h dvalid=0", dout, dvalid, last_result);
    end
    step(1'b0, 6'd2, 32'd0, 1'b1, 32'd2, 1'b0, 1'b0);
    step(1'b0, 6'd3, 32'd0, 1'b1, 32'd3, 1'b1, 1'b0);
    idle(5);

    // Overflow behaviour of product and sum.
    step(1'b1, 6'd20, 32'h7FFF_FFFF, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 6'd21, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 6'd20, 32'd0, 1'b1, 32'd2, 1'b0, 1'b0);
    step(1'b0, 6'd21, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0);
    idle(5);

    // Reset mid-vector: partial discarded, no result.
    step(1'b0, 6'd0, 32'd0, 1'b1, 32'd5, 1'b0, 1'b0);
    step(1'b0, 6'd1, 32'd0, 1'b1, 32'd5, 1'b0, 1'b0);
    @(negedge aclk);
    valid = 1'b0; last = 1'b0; we = 1'b0;
    areset = 1'b1;
    purge_from(0);
    acc_m = '0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    last_kill = cyc;
    checks++;
    if (dout !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset dout=%h busy=%b exp 0/0", dout, busy);
    end
    step(1'b0, 6'd2, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0);
    idle(5);

    // Randomized traffic over a randomly loaded RAM.
    for (int i = 0; i < 64; i++) step(1'b1, 6'(i), $urandom, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int vec = 0; vec < 40; vec++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if ($urandom_range(0, 24) == 0) begin
          step(1'b0, 6'd0, 32'd0, ($urandom_range(0, 1) == 1), $urandom, 1'b0, 1'b1);
        end
        step(($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)), $urandom,
             1'b1, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom,
             (k == len - 1), 1'b0);
      end
    end
    idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
